// File: rtl/usb_phy_seq_pkg.sv
// Shared state encoding, pin-level table and 50 MHz timing defaults for the PHY sequencer.
package usb_phy_seq_pkg;

    typedef enum logic [2:0] {
        ST_STRAP = 3'd0,
        ST_HOLD  = 3'd1,
        ST_WAIT  = 3'd2,
        ST_READY = 3'd3,
        ST_FAIL  = 3'd4
    } state_e;

    // Defaults for a 50 MHz clock; STATUS_TIMEOUT is 1 ms.
    localparam int unsigned DEF_STRAP_CYCLES   = 16;
    localparam int unsigned DEF_HOLD_CYCLES    = 4;
    localparam int unsigned DEF_STATUS_TIMEOUT = 50000;
    localparam int unsigned DEF_MAX_RETRY      = 3;
    localparam int unsigned DEF_CNT_W          = 20;

    typedef struct packed {
        logic strap_en;
        logic phy_reset_n;
        logic usb_reset_n;
        logic out_enable;
        logic ready;
        logic fail;
    } pins_t;

    // Pin levels for each state; unknown encodings fall back to the strap window.
    function automatic pins_t state_pins(state_e st);
        pins_t p;
        unique case (st)
            ST_STRAP: p = '{strap_en: 1'b1, phy_reset_n: 1'b0, usb_reset_n: 1'b0,
                            out_enable: 1'b0, ready: 1'b0, fail: 1'b0};
            ST_HOLD:  p = '{strap_en: 1'b1, phy_reset_n: 1'b1, usb_reset_n: 1'b0,
                            out_enable: 1'b0, ready: 1'b0, fail: 1'b0};
            ST_WAIT:  p = '{strap_en: 1'b0, phy_reset_n: 1'b1, usb_reset_n: 1'b1,
                            out_enable: 1'b1, ready: 1'b0, fail: 1'b0};
            ST_READY: p = '{strap_en: 1'b0, phy_reset_n: 1'b1, usb_reset_n: 1'b1,
                            out_enable: 1'b1, ready: 1'b1, fail: 1'b0};
            ST_FAIL:  p = '{strap_en: 1'b0, phy_reset_n: 1'b0, usb_reset_n: 1'b0,
                            out_enable: 1'b0, ready: 1'b0, fail: 1'b1};
            default:  p = '{strap_en: 1'b1, phy_reset_n: 1'b0, usb_reset_n: 1'b0,
                            out_enable: 1'b0, ready: 1'b0, fail: 1'b0};
        endcase
        return p;
    endfunction

endpackage

// File: rtl/synch_2.sv
// Generic two-flop synchronizer with a selectable reset level.
module synch_2 #(
    parameter bit RESET_VAL = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // Two back-to-back flops resolve metastability on the asynchronous input.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/usb_phy_seq.sv
// USB 3.0 PHY power-up sequencer: strap window, reset release and PHY_STATUS handshake.
module usb_phy_seq
    import usb_phy_seq_pkg::*;
#(
    parameter int unsigned STRAP_CYCLES   = DEF_STRAP_CYCLES,
    parameter int unsigned HOLD_CYCLES    = DEF_HOLD_CYCLES,
    parameter int unsigned STATUS_TIMEOUT = DEF_STATUS_TIMEOUT,
    parameter int unsigned MAX_RETRY      = DEF_MAX_RETRY,
    parameter int unsigned CNT_W          = DEF_CNT_W
) (
    input  logic       clk_50,
    input  logic       reset,
    input  logic       restart,
    input  logic       phy_status_async,
    output logic       strap_en,
    output logic       phy_reset_n,
    output logic       usb_reset_n,
    output logic       out_enable,
    output logic       ready,
    output logic       fail,
    output logic [1:0] retry_count
);

    localparam logic [CNT_W-1:0] StrapLast   = CNT_W'(STRAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] HoldLast    = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] TimeoutLast = CNT_W'(STATUS_TIMEOUT - 1);
    localparam logic [1:0]       MaxRetry    = 2'(MAX_RETRY);

    logic phy_status_s;

    // Idles high so a reset PHY looks "not ready" until the pin is really sampled.
    synch_2 #(
        .RESET_VAL (1'b1)
    ) u_status_sync (
        .clk_i (clk_50),
        .rst_i (reset),
        .d_i   (phy_status_async),
        .q_o   (phy_status_s)
    );

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       retry_q, retry_d;
    pins_t            pins_q, pins_d;

    // Next state, dwell counter and retry bookkeeping; pins follow the next state.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_W'(1);
        retry_d = retry_q;
        unique case (state_q)
            ST_STRAP: if (cnt_q == StrapLast) state_d = ST_HOLD;
            ST_HOLD:  if (cnt_q == HoldLast) state_d = ST_WAIT;
            ST_WAIT: begin
                // Status beats a coincident timeout.
                if (!phy_status_s) begin
                    state_d = ST_READY;
                end else if (cnt_q == TimeoutLast) begin
                    if (retry_q == MaxRetry) begin
                        state_d = ST_FAIL;
                    end else begin
                        state_d = ST_STRAP;
                        retry_d = retry_q + 2'd1;
                    end
                end
            end
            ST_READY, ST_FAIL: cnt_d = cnt_q;
            default: state_d = ST_STRAP;
        endcase
        if (state_d != state_q) cnt_d = '0;
        if (restart) begin
            state_d = ST_STRAP;
            cnt_d   = '0;
            retry_d = '0;
        end
        pins_d = state_pins(state_d);
    end

    // State, counter and registered pin levels all update on the same edge.
    always_ff @(posedge clk_50) begin
        if (reset) begin
            state_q <= ST_STRAP;
            cnt_q   <= '0;
            retry_q <= '0;
            pins_q  <= state_pins(ST_STRAP);
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            retry_q <= retry_d;
            pins_q  <= pins_d;
        end
    end

    assign strap_en    = pins_q.strap_en;
    assign phy_reset_n = pins_q.phy_reset_n;
    assign usb_reset_n = pins_q.usb_reset_n;
    assign out_enable  = pins_q.out_enable;
    assign ready       = pins_q.ready;
    assign fail        = pins_q.fail;
    assign retry_count = retry_q;

endmodule
